rgb_mode_pwm: RTL and testbench
===============================

Name: rgb_mode_pwm

Overview:
- Downstream consumer of the debounced push-button level in the rgb_display design.
- Each clean press (0->1 transition of the debounced level) advances a colour-mode state machine: OFF, RED, GREEN, BLUE, WHITE, BREATHE, then back to OFF.
- The selected mode drives the three RGB LED channels through a shared PWM counter at a fixed brightness.
- In BREATHE mode the blue channel ramps its duty up and down in a triangle wave.

Parameters:
- PRESCALE, 4, clk cycles per PWM counter increment (>=1); 1 = increment every cycle.
- DUTY, 8'd64, fixed duty for static modes; the channel is high while pwm_cnt < DUTY.
- BREATHE_STEP, 20'd390_625, clk cycles per breathe-duty step of +/-1 (about 2 s full up/down period at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz
- nrst  input  1  asynchronous active-low reset
- btn_level  input  1  debounced button level, already synchronous to clk
- led_r  output  1  red channel PWM, registered
- led_g  output  1  green channel PWM, registered
- led_b  output  1  blue channel PWM, registered
- mode  output  3  current mode: 0 OFF, 1 RED, 2 GREEN, 3 BLUE, 4 WHITE, 5 BREATHE

Behaviour:
- Reset (async, nrst=0): mode=0, led_r/g/b=0, btn_d=0, prescale counter=0, pwm_cnt=0, breathe_duty=0, breathe_dir=up, step counter=0. Every output is 0 while reset is asserted.
- Edge detect: btn_d is btn_level registered; press = btn_level & ~btn_d. A level held high gives exactly one press, so a held button never auto-repeats.
- Mode FSM: on a clk edge where press=1, mode <= (mode==5) ? 0 : mode+1. It is updated on that same edge. Codes 6 and 7 are unreachable; if ever present they return to 0 on the next clk.
- Entering BREATHE (mode 4->5): breathe_duty=0, breathe_dir=up, step counter=0, all loaded on the same edge as the mode change.
- Prescaler:
  - counts 0..PRESCALE-1;
  - tick=1 when the count equals PRESCALE-1, and the counter then wraps to 0;
  - PRESCALE=1 gives tick=1 every cycle.
- pwm_cnt: 8-bit, increments on tick and wraps 255->0. It free-runs in every mode and is not reset by mode changes.
- Channel compare, combinational on the current mode and pwm_cnt:
  - on = (pwm_cnt < D), with D = DUTY in static modes and breathe_duty in BREATHE;
  - D=0 means never on; D=255 means on 255 of 256 counts.
- Channel map:
  - OFF: none.
  - RED: r.
  - GREEN: g.
  - BLUE: b.
  - WHITE: r, g and b.
  - BREATHE: b only, using breathe_duty.
- Output latency: led_* are registered from the compare, so they lag mode/pwm_cnt by 1 clk. After a press, mode changes 1 clk after the press edge is sampled, and the LEDs reflect the new mode 1 clk later.
- Breathe ramp, active only in mode 5:
  - the step counter counts 0..BREATHE_STEP-1;
  - on its wrap, breathe_duty changes by +1 (up) or -1 (down);
  - if up and duty==254, the step gives 255 and dir <= down;
  - if down and duty==1, the step gives 0 and dir <= up;
  - the duty therefore never wraps, with range 0..255 inclusive.
- Outside mode 5, the step counter and breathe_duty hold their values; they are reloaded on the next entry to mode 5.
- Simultaneous events: press and tick/step wrap on the same edge are all applied. A press takes effect immediately, and the new mode's compare uses the already-updated pwm_cnt.
- Reset mid-operation (e.g. mid-breathe): everything returns to reset values asynchronously, and the next press gives mode 1.

Test Plan:
- Reset, then btn_level held 0 for 1000 cycles -> mode=0 and led_r/g/b=0 throughout; nrst low mid-run forces all outputs 0 immediately.
- Six single presses (btn_level high for 20 cycles, low for 20) -> mode steps 1,2,3,4,5,0. mode changes on the cycle after btn_level rises. btn_level held high for 500 cycles -> exactly one increment.
- PRESCALE=1, DUTY=64, mode RED -> led_r high for exactly 64 of every 256 cycles, led_g=led_b=0. DUTY=0 -> led_r never high.
- Mode WHITE, PRESCALE=4, DUTY=128 -> r, g and b are identical, with a high time of 512 cycles per 1024-cycle period.
- BREATHE with BREATHE_STEP=4, PRESCALE=1:
  - breathe_duty starts at 0 and reaches 255 after 255x4 cycles;
  - it then decrements to 0 and climbs again, with no wrap past 255 or 0;
  - led_r=led_g=0.
- Press on the same cycle as a step-counter wrap in BREATHE -> mode=0 and the LEDs go low on the next clk. Re-entering BREATHE restarts the duty at 0, direction up.

Source files
------------

// File: rtl/rgb_mode_pwm.sv
// Button-stepped RGB colour mode selector driving three PWM LED channels.
// BREATHE mode ramps the blue duty in a triangle wave.
module rgb_mode_pwm #(
    parameter int          PRESCALE     = 4,
    parameter logic [7:0]  DUTY         = 8'd64,
    parameter logic [19:0] BREATHE_STEP = 20'd390_625
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       btn_level,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [2:0] mode
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
    localparam logic [19:0]   STEP_MAX = BREATHE_STEP - 20'd1;

    typedef enum logic [2:0] {
        M_OFF     = 3'd0,
        M_RED     = 3'd1,
        M_GREEN   = 3'd2,
        M_BLUE    = 3'd3,
        M_WHITE   = 3'd4,
        M_BREATHE = 3'd5
    } mode_t;

    mode_t          r_mode;
    logic           r_btn_d;
    logic [PW-1:0]  r_pre;
    logic [7:0]     r_pwm;
    logic [7:0]     r_bduty;
    logic           r_bdir_up;
    logic [19:0]    r_step;
    logic           r_led_r;
    logic           r_led_g;
    logic           r_led_b;

    logic w_press;
    logic w_tick;
    logic w_step_wrap;
    logic w_on_fix;
    logic w_on_br;
    logic w_r;
    logic w_g;
    logic w_b;

    assign w_press     = btn_level & ~r_btn_d;
    assign w_tick      = (r_pre == PRE_MAX);
    assign w_step_wrap = (r_step == STEP_MAX);
    assign w_on_fix    = (r_pwm < DUTY);
    assign w_on_br     = (r_pwm < r_bduty);

    always_comb begin
        w_r = 1'b0;
        w_g = 1'b0;
        w_b = 1'b0;
        case (r_mode)
            M_RED:     w_r = w_on_fix;
            M_GREEN:   w_g = w_on_fix;
            M_BLUE:    w_b = w_on_fix;
            M_WHITE: begin
                w_r = w_on_fix;
                w_g = w_on_fix;
                w_b = w_on_fix;
            end
            M_BREATHE: w_b = w_on_br;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mode    <= M_OFF;
            r_btn_d   <= 1'b0;
            r_pre     <= '0;
            r_pwm     <= 8'd0;
            r_bduty   <= 8'd0;
            r_bdir_up <= 1'b1;
            r_step    <= 20'd0;
            r_led_r   <= 1'b0;
            r_led_g   <= 1'b0;
            r_led_b   <= 1'b0;
        end else begin
            r_btn_d <= btn_level;
            r_pre   <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick)
                r_pwm <= r_pwm + 8'd1;
            r_led_r <= w_r;
            r_led_g <= w_g;
            r_led_b <= w_b;

            case (r_mode)
                M_OFF, M_RED, M_GREEN, M_BLUE, M_WHITE:
                    if (w_press)
                        r_mode <= mode_t'(r_mode + 3'd1);
                M_BREATHE:
                    if (w_press)
                        r_mode <= M_OFF;
                default:
                    r_mode <= M_OFF;
            endcase

            // Ramp saturates at 0 and 255 by reversing direction.
            if (r_mode == M_BREATHE) begin
                if (w_step_wrap) begin
                    r_step <= 20'd0;
                    if (r_bdir_up) begin
                        r_bduty <= r_bduty + 8'd1;
                        if (r_bduty == 8'd254)
                            r_bdir_up <= 1'b0;
                    end else begin
                        r_bduty <= r_bduty - 8'd1;
                        if (r_bduty == 8'd1)
                            r_bdir_up <= 1'b1;
                    end
                end else begin
                    r_step <= r_step + 20'd1;
                end
            end

            if (w_press && r_mode == M_WHITE) begin
                r_bduty   <= 8'd0;
                r_bdir_up <= 1'b1;
                r_step    <= 20'd0;
            end
        end
    end

    assign led_r = r_led_r;
    assign led_g = r_led_g;
    assign led_b = r_led_b;
    assign mode  = r_mode;

endmodule

// File: tb/tb_rgb_mode_pwm.sv
// Bench for rgb_mode_pwm: three parameterisations share one button
// and are checked every cycle against an arithmetic reference model.
module tb_rgb_mode_pwm;

    localparam int BS = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic btn_level = 1'b0;
    logic lr[3];
    logic lg[3];
    logic lb[3];
    logic [2:0] md[3];

    int mp[3] = '{1, 4, 1};
    int mduty[3] = '{64, 128, 0};

    int m_n[3];
    int m_bd[3];
    int m_mode[3];
    int m_in5[3];
    int m_led[3][3];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    rgb_mode_pwm #(.PRESCALE(1), .DUTY(8'd64), .BREATHE_STEP(20'd4)) u0 (
        .clk(clk), .nrst(nrst), .btn_level(btn_level),
        .led_r(lr[0]), .led_g(lg[0]), .led_b(lb[0]), .mode(md[0]));
    rgb_mode_pwm #(.PRESCALE(4), .DUTY(8'd128), .BREATHE_STEP(20'd4)) u1 (
        .clk(clk), .nrst(nrst), .btn_level(btn_level),
        .led_r(lr[1]), .led_g(lg[1]), .led_b(lb[1]), .mode(md[1]));
    rgb_mode_pwm #(.PRESCALE(1), .DUTY(8'd0), .BREATHE_STEP(20'd4)) u2 (
        .clk(clk), .nrst(nrst), .btn_level(btn_level),
        .led_r(lr[2]), .led_g(lg[2]), .led_b(lb[2]), .mode(md[2]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp)
            passes++;
        else
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Triangle duty after k steps: 0..255 then back down, period 510.
    function automatic int tri_f(input int k);
        int p;
        p = k % 510;
        return (p <= 255) ? p : 510 - p;
    endfunction

    task automatic model_reset(input int i);
        m_n[i] = 0;
        m_bd[i] = 0;
        m_mode[i] = 0;
        m_in5[i] = 0;
        for (int c = 0; c < 3; c++)
            m_led[i][c] = 0;
    endtask

    task automatic model_edge();
        int pwm;
        int d;
        int on;
        bit press;
        for (int i = 0; i < 3; i++) begin
            if (!nrst) begin
                model_reset(i);
                continue;
            end
            pwm = (m_n[i] / mp[i]) % 256;
            d = (m_mode[i] == 5) ? tri_f(m_in5[i] / BS) : mduty[i];
            on = (pwm < d) ? 1 : 0;
            m_led[i][0] = (m_mode[i] == 1 || m_mode[i] == 4) ? on : 0;
            m_led[i][1] = (m_mode[i] == 2 || m_mode[i] == 4) ? on : 0;
            m_led[i][2] = (m_mode[i] == 3 || m_mode[i] == 4 || m_mode[i] == 5) ? on : 0;
            press = btn_level && (m_bd[i] == 0);
            if (m_mode[i] == 5)
                m_in5[i]++;
            if (press) begin
                if (m_mode[i] == 4)
                    m_in5[i] = 0;
                m_mode[i] = (m_mode[i] == 5) ? 0 : m_mode[i] + 1;
            end
            m_n[i]++;
            m_bd[i] = btn_level ? 1 : 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.mode", i), int'(md[i]), m_mode[i]);
            chk($sformatf("u%0d.led_r", i), int'(lr[i]), m_led[i][0]);
            chk($sformatf("u%0d.led_g", i), int'(lg[i]), m_led[i][1]);
            chk($sformatf("u%0d.led_b", i), int'(lb[i]), m_led[i][2]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic press(input int hi, input int lo);
        btn_level = 1'b1;
        repeat (hi) cyc();
        btn_level = 1'b0;
        repeat (lo) cyc();
    endtask

    typedef struct {
        int hi;
        int lo;
        int exp_mode;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a;
        int cnt_b;
        int cnt_c;
        int m0;
        int guard;

        tbl[0] = '{20, 20, 1};
        tbl[1] = '{20, 20, 2};
        tbl[2] = '{20, 20, 3};
        tbl[3] = '{20, 20, 4};
        tbl[4] = '{20, 20, 5};
        tbl[5] = '{20, 20, 0};

        for (int i = 0; i < 3; i++)
            model_reset(i);
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst.u%0d.mode", i), int'(md[i]), 0);
            chk($sformatf("rst.u%0d.rgb", i), int'({lr[i], lg[i], lb[i]}), 0);
        end
        repeat (3) cyc();
        nrst = 1'b1;

        repeat (1000) cyc();

        for (int v = 0; v < 6; v++) begin
            btn_level = 1'b1;
            cyc();
            chk($sformatf("tbl%0d.mode", v), int'(md[0]), tbl[v].exp_mode);
            repeat (tbl[v].hi - 1) cyc();
            btn_level = 1'b0;
            repeat (tbl[v].lo) cyc();
            chk($sformatf("tbl%0d.hold", v), int'(md[1]), tbl[v].exp_mode);
        end

        m0 = int'(md[0]);
        press(500, 5);
        chk("held.one_step", int'(md[0]), (m0 + 1) % 6);

        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 0; k < 256; k++) begin
            cyc();
            cnt_a += int'(lr[0]);
            cnt_b += int'(lr[2]);
            cnt_c += int'(lg[0]) + int'(lb[0]);
        end
        chk("red.high64", cnt_a, 64);
        chk("red.duty0", cnt_b, 0);
        chk("red.gb_off", cnt_c, 0);

        press(3, 3);
        press(3, 3);
        press(3, 3);
        chk("white.mode", int'(md[1]), 4);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 1024; k++) begin
            cyc();
            cnt_a += int'(lr[1]);
            if (lr[1] != lg[1] || lr[1] != lb[1])
                cnt_b++;
        end
        chk("white.high512", cnt_a, 512);
        chk("white.rgb_eq", cnt_b, 0);

        btn_level = 1'b1;
        cyc();
        btn_level = 1'b0;
        chk("breathe.mode", int'(md[0]), 5);
        cnt_a = 0;
        for (int k = 0; k < 2300; k++) begin
            cyc();
            cnt_a += int'(lr[0]) + int'(lg[0]);
        end
        chk("breathe.rg_off", cnt_a, 0);

        guard = 0;
        while ((m_in5[0] % BS) != BS - 1 && guard < 10) begin
            cyc();
            guard++;
        end
        chk("wrap.align", guard < 10 ? 1 : 0, 1);
        btn_level = 1'b1;
        cyc();
        btn_level = 1'b0;
        chk("wrap.mode0", int'(md[0]), 0);
        cyc();
        chk("wrap.led_b", int'(lb[0]), 0);

        repeat (4) press(2, 2);
        btn_level = 1'b1;
        cyc();
        btn_level = 1'b0;
        chk("reenter.mode", int'(md[0]), 5);
        cnt_a = 0;
        for (int k = 0; k < BS; k++) begin
            cyc();
            cnt_a += int'(lb[0]);
        end
        chk("reenter.duty0", cnt_a, 0);

        repeat (300) cyc();
        #2;
        nrst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst.u%0d.mode", i), int'(md[i]), 0);
            chk($sformatf("midrst.u%0d.rgb", i), int'({lr[i], lg[i], lb[i]}), 0);
        end
        repeat (3) cyc();
        nrst = 1'b1;
        press(3, 3);
        chk("midrst.first_press", int'(md[0]), 1);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0)
                btn_level = ~btn_level;
            cyc();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
